// File: rtl/chr_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : chr_sram_arbiter
// Purpose  : Shares one async 16-bit SRAM between a high-priority PPU read port
//            and a CPU read/write port, sequencing every SRAM bus cycle.
// Revision : 1.0 - initial release
// ============================================================================
module chr_sram_arbiter #(
    parameter int RD_CYC      = 2,
    parameter int WE_CYC      = 2,
    parameter int MAX_PPU_RUN = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ppu_req,
    input  logic [20:0] i_ppu_addr,
    output logic        o_ppu_ack,
    output logic [7:0]  o_ppu_rdata,
    input  logic        i_cpu_req,
    input  logic        i_cpu_wn,
    input  logic [20:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_lb_n,
    output logic        o_sram_ub_n,
    output logic [15:0] o_sram_dq_out,
    output logic        o_sram_dq_oe,
    input  logic [15:0] i_sram_dq
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_SU = 3'd2,
        ST_WR_PW = 3'd3,
        ST_WR_HD = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] c_rd_last = 4'(RD_CYC - 1);
    localparam logic [3:0] c_we_last = 4'(WE_CYC - 1);
    localparam logic [3:0] c_max_run = 4'(MAX_PPU_RUN);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_owner_cpu;
    logic        r_lane_hi;

    logic        w_ppu_grant;
    logic        w_cpu_grant;
    logic [20:0] w_addr;
    logic        w_read;

    // PPU wins unless the CPU has already waited out MAX_PPU_RUN PPU grants.
    always_comb begin
        w_ppu_grant = i_ppu_req && !(i_cpu_req && (r_starve_cnt == c_max_run));
        w_cpu_grant = !w_ppu_grant && i_cpu_req;
        w_addr      = w_ppu_grant ? i_ppu_addr : i_cpu_addr;
        w_read      = w_ppu_grant || i_cpu_wn;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_starve_cnt  <= '0;
            r_owner_cpu   <= 1'b0;
            r_lane_hi     <= 1'b0;
            o_ppu_ack     <= 1'b0;
            o_ppu_rdata   <= '0;
            o_cpu_ack     <= 1'b0;
            o_cpu_rdata   <= '0;
            o_sram_addr   <= '0;
            o_sram_ce_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
            o_sram_lb_n   <= 1'b1;
            o_sram_ub_n   <= 1'b1;
            o_sram_dq_out <= '0;
            o_sram_dq_oe  <= 1'b0;
        end else begin
            o_ppu_ack <= 1'b0;
            o_cpu_ack <= 1'b0;

            if (!i_cpu_req) begin
                r_starve_cnt <= '0;
            end else if (r_state == ST_IDLE) begin
                if (w_ppu_grant && (r_starve_cnt != c_max_run))
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                else if (w_cpu_grant)
                    r_starve_cnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ppu_grant || w_cpu_grant) begin
                        r_owner_cpu <= w_cpu_grant;
                        r_lane_hi   <= w_addr[0];
                        r_cnt       <= '0;
                        o_sram_addr <= w_addr[20:1];
                        o_sram_ce_n <= 1'b0;
                        o_sram_lb_n <= w_addr[0];
                        o_sram_ub_n <= !w_addr[0];
                        if (w_read) begin
                            o_sram_oe_n <= 1'b0;
                            r_state     <= ST_RD;
                        end else begin
                            o_sram_dq_out <= {i_cpu_wdata, i_cpu_wdata};
                            o_sram_dq_oe  <= 1'b1;
                            r_state       <= ST_WR_SU;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == c_rd_last) begin
                        if (r_owner_cpu) begin
                            o_cpu_rdata <= r_lane_hi ? i_sram_dq[15:8] : i_sram_dq[7:0];
                            o_cpu_ack   <= 1'b1;
                        end else begin
                            o_ppu_rdata <= r_lane_hi ? i_sram_dq[15:8] : i_sram_dq[7:0];
                            o_ppu_ack   <= 1'b1;
                        end
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        o_sram_lb_n <= 1'b1;
                        o_sram_ub_n <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WR_SU: begin
                    o_sram_we_n <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_WR_PW;
                end
                ST_WR_PW: begin
                    if (r_cnt == c_we_last) begin
                        o_sram_we_n <= 1'b1;
                        r_state     <= ST_WR_HD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WR_HD: begin
                    o_cpu_ack    <= 1'b1;
                    o_sram_ce_n  <= 1'b1;
                    o_sram_lb_n  <= 1'b1;
                    o_sram_ub_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chr_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_chr_sram_arbiter
// Purpose  : Directed bench with an async SRAM model and an ack scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chr_sram_arbiter;

    localparam int RD_CYC      = 2;
    localparam int WE_CYC      = 2;
    localparam int MAX_PPU_RUN = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ppu_req, cpu_req, cpu_wn;
    logic [20:0] ppu_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ppu_ack, cpu_ack;
    logic [7:0]  ppu_rdata, cpu_rdata;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq = 16'h0;

    always #5 clk = ~clk;

    chr_sram_arbiter #(
        .RD_CYC      (RD_CYC),
        .WE_CYC      (WE_CYC),
        .MAX_PPU_RUN (MAX_PPU_RUN)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_ppu_req     (ppu_req),
        .i_ppu_addr    (ppu_addr),
        .o_ppu_ack     (ppu_ack),
        .o_ppu_rdata   (ppu_rdata),
        .i_cpu_req     (cpu_req),
        .i_cpu_wn      (cpu_wn),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_wdata   (cpu_wdata),
        .o_cpu_ack     (cpu_ack),
        .o_cpu_rdata   (cpu_rdata),
        .o_sram_addr   (sram_addr),
        .o_sram_ce_n   (sram_ce_n),
        .o_sram_oe_n   (sram_oe_n),
        .o_sram_we_n   (sram_we_n),
        .o_sram_lb_n   (sram_lb_n),
        .o_sram_ub_n   (sram_ub_n),
        .o_sram_dq_out (sram_dq_out),
        .o_sram_dq_oe  (sram_dq_oe),
        .i_sram_dq     (sram_dq)
    );

    // Async SRAM: a write commits when WE rises while CE is still low.
    logic [15:0] mem [logic [19:0]];
    logic        prev_we  = 1'b1;
    logic        mem_init = 1'b0;

    always @(negedge clk) begin : sram_model
        logic [15:0] w;
        if (!mem_init) begin
            mem[20'h00000] = 16'h1234;
            mem[20'h00001] = 16'h0000;
            mem[20'h00002] = 16'hBEEF;
            mem[20'hFFFFF] = 16'h0000;
            mem_init = 1'b1;
        end
        if (!prev_we && sram_we_n && !sram_ce_n && sram_dq_oe) begin
            w = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0;
            if (!sram_lb_n) w[7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) w[15:8] = sram_dq_out[15:8];
            mem[sram_addr] = w;
        end
        prev_we = sram_we_n;
        sram_dq = (!sram_ce_n && !sram_oe_n && mem.exists(sram_addr)) ? mem[sram_addr] : 16'h0;
    end

    function automatic logic [15:0] rd_mem(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'h0;
    endfunction

    typedef struct {
        logic       is_cpu;
        logic       chk;
        logic [7:0] data;
        int         lat;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc = 0, grant_cyc = 0, last_ppu_ack_cyc = 0, we_low = 0;
    logic prev_ce = 1'b1, granted = 1'b0;
    logic ppu_hold = 1'b0, cpu_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_cpu, input logic chk, input logic [7:0] d,
                        input int lat, input string tag);
        sb.push_back('{is_cpu, chk, d, lat, tag});
    endtask

    // One clock; outputs sampled 1 ns after the rising edge, acks scored here.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_ce && !sram_ce_n) begin
            grant_cyc = cyc;
            granted   = 1'b1;
            we_low    = 0;
        end
        if (!sram_we_n) we_low++;
        prev_ce = sram_ce_n;
        if (ppu_ack || cpu_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'({ppu_ack, cpu_ack}), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_owner"}, 32'({ppu_ack, cpu_ack}), 32'({!e.is_cpu, e.is_cpu}));
                if (e.chk)
                    check({e.tag, "_rdata"}, 32'(cpu_ack ? cpu_rdata : ppu_rdata), 32'(e.data));
                // ack cycle counted from the first cycle after the grant edge
                check({e.tag, "_latency"}, 32'(cyc - grant_cyc + 1), 32'(e.lat));
            end
            if (ppu_ack) begin
                last_ppu_ack_cyc = cyc;
                if (!ppu_hold) ppu_req = 1'b0;
            end
            if (cpu_ack && !cpu_hold) cpu_req = 1'b0;
        end
    endtask

    task automatic wait_grant(input int max);
        int n = 0;
        granted = 1'b0;
        while (!granted && n < max) begin
            tick();
            n++;
        end
        check("grant_timeout", 32'(granted), 32'd1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; ppu_req = 1'b0; cpu_req = 1'b0; cpu_wn = 1'b1;
        ppu_addr = '0; cpu_addr = '0; cpu_wdata = '0;

        // Reset
        repeat (3) tick();
        check("rst_ce_n",  32'(sram_ce_n), 32'd1);
        check("rst_oe_n",  32'(sram_oe_n), 32'd1);
        check("rst_we_n",  32'(sram_we_n), 32'd1);
        check("rst_lanes", 32'({sram_lb_n, sram_ub_n}), 32'd3);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_acks",  32'({ppu_ack, cpu_ack}), 32'd0);
        check("rst_addr",  32'(sram_addr), 32'd0);
        check("rst_dqout", 32'(sram_dq_out), 32'd0);
        check("rst_rdata", 32'({ppu_rdata, cpu_rdata}), 32'd0);
        rstn = 1'b1;
        tick();

        // CPU write A5 to byte 3: word 1, upper lane
        cpu_addr = 21'h000003; cpu_wdata = 8'hA5; cpu_wn = 1'b0; cpu_req = 1'b1;
        push(1'b1, 1'b0, 8'h00, WE_CYC + 3, "wr_a5");
        wait_grant(10);
        check("wr_addr",  32'(sram_addr), 32'h1);
        check("wr_lanes", 32'({sram_ub_n, sram_lb_n}), 32'b01);
        check("wr_dqout", 32'(sram_dq_out), 32'hA5A5);
        check("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
        drain(20);
        check("wr_we_low", 32'(we_low), 32'(WE_CYC));
        check("wr_mem",    32'(rd_mem(20'h1)), 32'hA500);

        // PPU reads of both lanes of word 0
        ppu_addr = 21'h000000; ppu_req = 1'b1;
        push(1'b0, 1'b1, 8'h34, RD_CYC + 1, "ppu_b0");
        drain(20);
        ppu_addr = 21'h000001; ppu_req = 1'b1;
        push(1'b0, 1'b1, 8'h12, RD_CYC + 1, "ppu_b1");
        drain(20);

        // Simultaneous requests: PPU first, CPU on the following IDLE cycle
        ppu_addr = 21'h000001; ppu_req = 1'b1;
        cpu_addr = 21'h000003; cpu_wn = 1'b1; cpu_req = 1'b1;
        push(1'b0, 1'b1, 8'h12, RD_CYC + 1, "sim_ppu");
        push(1'b1, 1'b1, 8'hA5, RD_CYC + 1, "sim_cpu");
        drain(30);
        check("sim_cpu_gap", 32'(grant_cyc - last_ppu_ack_cyc), 32'd2);

        // Starvation guard: 4 PPU then 1 CPU, twice
        ppu_hold = 1'b1; cpu_hold = 1'b1;
        ppu_addr = 21'h000000; cpu_addr = 21'h000001; cpu_wn = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < MAX_PPU_RUN; p++)
                push(1'b0, 1'b1, 8'h34, RD_CYC + 1, "stv_ppu");
            push(1'b1, 1'b1, 8'h12, RD_CYC + 1, "stv_cpu");
        end
        ppu_req = 1'b1; cpu_req = 1'b1;
        drain(200);
        ppu_req = 1'b0; cpu_req = 1'b0; ppu_hold = 1'b0; cpu_hold = 1'b0;
        tick();

        // Request dropped after grant still completes
        cpu_addr = 21'h000000; cpu_wn = 1'b1; cpu_req = 1'b1;
        push(1'b1, 1'b1, 8'h34, RD_CYC + 1, "drop_cpu");
        wait_grant(10);
        cpu_req = 1'b0;
        drain(20);

        // Top address: word FFFFF, upper lane
        cpu_addr = 21'h1FFFFF; cpu_wdata = 8'h5A; cpu_wn = 1'b0; cpu_req = 1'b1;
        push(1'b1, 1'b0, 8'h00, WE_CYC + 3, "top_wr");
        wait_grant(10);
        check("top_addr",  32'(sram_addr), 32'hFFFFF);
        check("top_lanes", 32'({sram_ub_n, sram_lb_n}), 32'b01);
        drain(20);
        check("top_mem", 32'(rd_mem(20'hFFFFF)), 32'h5A00);
        ppu_addr = 21'h1FFFFF; ppu_req = 1'b1;
        push(1'b0, 1'b1, 8'h5A, RD_CYC + 1, "top_rd");
        drain(20);

        // Reset in the first WE-low cycle aborts the write
        tick();
        cpu_addr = 21'h000004; cpu_wdata = 8'h77; cpu_wn = 1'b0; cpu_req = 1'b1;
        wait_grant(10);
        tick();
        check("abort_we_low", 32'(sram_we_n), 32'd0);
        rstn = 1'b0; cpu_req = 1'b0;
        tick();
        check("abort_we_n",  32'(sram_we_n), 32'd1);
        check("abort_ce_n",  32'(sram_ce_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_ack",   32'(cpu_ack), 32'd0);
        tick();
        rstn = 1'b1;
        repeat (8) tick();
        check("abort_mem", 32'(rd_mem(20'h2)), 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
